capture_controller: RTL and testbench
=====================================

CAPTURE_CONTROLLER -- requirements
Module: capture_controller

Interface
REQ-001 Parameter ADDR_W, default 16: width of the sample-memory address and the sample counter.
REQ-002 Parameter DATA_W, default 12: ADC sample width.
REQ-003 Parameter SAMPLE_DIV, default 100: clk cycles between conversion ticks; legal range 2..65535.
REQ-004 Parameter TIMEOUT, default 255: maximum clk cycles spent waiting for adc_valid after conv_start.
REQ-005 One clock; reset is synchronous and active-high. The clock port is clk and the reset port is reset.
REQ-006 clk  in  1  system clock; all state updates on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 start  in  1  single-cycle request to begin a capture run.
REQ-009 stop  in  1  abort the run in progress.
REQ-010 num_samples  in  ADDR_W  samples per run; 0 means 2^ADDR_W.
REQ-011 adc_valid  in  1  single-cycle strobe: adc_data holds a completed conversion.
REQ-012 adc_data  in  DATA_W  conversion result.
REQ-013 conv_start  out  1  single-cycle pulse that starts one ADC conversion.
REQ-014 mem_we  out  1  sample-memory write enable.
REQ-015 mem_addr  out  ADDR_W  sample-memory write address.
REQ-016 mem_wdata  out  DATA_W  sample-memory write data.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  single-cycle pulse when a run completes normally.
REQ-019 overrun  out  1  sticky flag: a tick arrived while the previous sample was still pending.
REQ-020 timeout_err  out  1  sticky flag: adc_valid did not arrive within TIMEOUT cycles.

Function
REQ-021 The FSM SHALL have the states IDLE, ARMED, WAIT_TICK, CONVERT, WAIT_DATA, WRITE and DONE; all outputs are decoded from registered state and registers only.
REQ-022 In IDLE, start SHALL load the remaining count from num_samples, set mem_addr to 0, clear both sticky flags, and go to ARMED if the trigger feature is compiled in, otherwise to WAIT_TICK.
REQ-023 While busy, the divider SHALL count from SAMPLE_DIV-1 down to 0 and raise tick for one cycle at 0, then reload; the divider starts at SAMPLE_DIV-1 on entry to WAIT_TICK from IDLE or ARMED.
REQ-024 In WAIT_TICK, tick SHALL move the FSM to CONVERT; CONVERT SHALL assert conv_start for exactly one cycle and then go to WAIT_DATA.
REQ-025 In WAIT_DATA, adc_valid SHALL capture adc_data into mem_wdata and move the FSM to WRITE.
REQ-026 If TIMEOUT cycles elapse in WAIT_DATA without adc_valid, the block SHALL set timeout_err and go to DONE.
REQ-027 WRITE SHALL assert mem_we for one cycle at the current mem_addr, then increment mem_addr and decrement the count; at count 1 it SHALL go to DONE, otherwise to WAIT_TICK.
REQ-028 A tick in CONVERT, WAIT_DATA or WRITE SHALL set overrun and be dropped; no extra conversion is issued.
REQ-029 DONE SHALL assert done for one cycle, then return to IDLE; mem_addr holds the count of samples written.
REQ-030 mem_addr SHALL wrap from 2^ADDR_W-1 to 0 only on the final write of a run with num_samples=0.
REQ-031 stop in any non-IDLE state SHALL force IDLE on the next cycle with no done pulse; a write already in WRITE completes in that cycle.
REQ-032 start while busy SHALL be ignored; stop and start in the same cycle in IDLE SHALL be treated as start ignored.
REQ-033 adc_valid outside WAIT_DATA SHALL be ignored.

Reset
REQ-034 reset SHALL force IDLE and drive conv_start, mem_we, busy, done, overrun and timeout_err to 0 and mem_addr and mem_wdata to 0; it takes priority over all inputs, including mid-run.

Configuration
REQ-035 Macro CAPTURE_TRIGGER_EN defined: adds input trig (1 bit, synchronous to clk); ARMED waits for a trig rising edge (registered previous value) and then enters WAIT_TICK; stop exits ARMED.
REQ-036 Macro CAPTURE_TRIGGER_EN undefined: no trig port and no ARMED state; start goes directly to WAIT_TICK.

Structure
REQ-037 A package capture_pkg SHALL hold the state enum type and the default parameter constants.
REQ-038 The address and remaining-count registers SHALL live in sub-module capture_addr_gen (synchronous load, increment and decrement, last-sample flag).

Verification
REQ-039 SAMPLE_DIV=4, num_samples=3, adc_valid 2 cycles after each conv_start -> 3 writes at addresses 0,1,2; conv_start pulses spaced 4 cycles apart; done pulses once; mem_addr=3.
REQ-040 adc_valid withheld for 255 cycles after conv_start -> timeout_err=1; done pulses; no mem_we.
REQ-041 SAMPLE_DIV=2 with adc_valid 3 cycles late -> overrun=1; exactly num_samples writes occur.
REQ-042 stop asserted in WAIT_DATA during sample 2 -> IDLE next cycle; busy=0; no done; 1 write total.
REQ-043 ADDR_W=4, num_samples=0 -> 16 writes at addresses 0..15; mem_addr=0 after DONE.
REQ-044 CAPTURE_TRIGGER_EN defined, start then trig held low for 50 cycles -> no conv_start; trig rises -> first conv_start SAMPLE_DIV+1 cycles later.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared types and default parameters for the capture controller.
// The ARMED state exists only when CAPTURE_TRIGGER_EN is defined.
package capture_pkg;

    localparam int ADDR_W_DEF     = 16;
    localparam int DATA_W_DEF     = 12;
    localparam int SAMPLE_DIV_DEF = 100;
    localparam int TIMEOUT_DEF    = 255;

    typedef enum logic [2:0] {
`ifdef CAPTURE_TRIGGER_EN
        ST_ARMED     = 3'd1,
`endif
        ST_IDLE      = 3'd0,
        ST_WAIT_TICK = 3'd2,
        ST_CONVERT   = 3'd3,
        ST_WAIT_DATA = 3'd4,
        ST_WRITE     = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

endpackage

// File: rtl/capture_addr_gen.sv
// Sample-memory write address and remaining-sample counter.
// A load value of zero stands for a full 2^ADDR_W run, hence the extra count bit.
module capture_addr_gen
    import capture_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] count_init,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W:0]   count_r;

    // address / remaining-count registers
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r  <= {ADDR_W{1'b0}};
            count_r <= {(ADDR_W+1){1'b0}};
        end else if (load) begin
            addr_r  <= {ADDR_W{1'b0}};
            if (count_init == {ADDR_W{1'b0}}) begin
                count_r <= {1'b1, {ADDR_W{1'b0}}};
            end else begin
                count_r <= {1'b0, count_init};
            end
        end else if (advance) begin
            addr_r  <= addr_r + ADDR_W'(1);
            count_r <= count_r - (ADDR_W+1)'(1);
        end
    end

    assign addr = addr_r;
    assign last = (count_r == (ADDR_W+1)'(1));

endmodule

// File: rtl/capture_controller.sv
// Paces ADC conversions from a clock divider and streams each sample to memory.
// Define CAPTURE_TRIGGER_EN to add the trig input and the ARMED wait state.
module capture_controller
    import capture_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] num_samples,
`ifdef CAPTURE_TRIGGER_EN
    input  logic              trig,
`endif
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    output logic              conv_start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic              timeout_err
);

    localparam int DIV_W = 16;
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
`ifdef CAPTURE_TRIGGER_EN
    localparam state_t ST_FIRST = ST_ARMED;
`else
    localparam state_t ST_FIRST = ST_WAIT_TICK;
`endif

    state_t            state_r;
    state_t            state_next_s;
    logic [DIV_W-1:0]  div_r;
    logic [TMO_W-1:0]  wait_cnt_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              overrun_r;
    logic              timeout_err_r;
    logic              run_start_s;
    logic              hold_div_s;
    logic              tick_s;
    logic              timeout_s;
    logic              overrun_set_s;
    logic              advance_s;
    logic              last_s;
    logic              trig_rise_s;
    logic [ADDR_W-1:0] addr_s;

`ifdef CAPTURE_TRIGGER_EN
    logic trig_prev_r;

    // previous trig level for rising-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            trig_prev_r <= 1'b0;
        end else begin
            trig_prev_r <= trig;
        end
    end

    assign trig_rise_s = trig & ~trig_prev_r;
    assign hold_div_s  = (state_r == ST_IDLE) || (state_r == ST_ARMED);
`else
    assign trig_rise_s = 1'b0;
    assign hold_div_s  = (state_r == ST_IDLE);
`endif

    // stop wins over a simultaneous start in IDLE
    assign run_start_s   = (state_r == ST_IDLE) && start && !stop;
    assign tick_s        = (state_r != ST_IDLE) && (div_r == {DIV_W{1'b0}});
    assign timeout_s     = (state_r == ST_WAIT_DATA) && !adc_valid && !stop &&
                           (wait_cnt_r == TMO_LAST);
    assign overrun_set_s = tick_s && ((state_r == ST_CONVERT) ||
                                      (state_r == ST_WAIT_DATA) ||
                                      (state_r == ST_WRITE));
    assign advance_s     = (state_r == ST_WRITE);

    capture_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .load       (run_start_s),
        .count_init (num_samples),
        .advance    (advance_s),
        .addr       (addr_s),
        .last       (last_s)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (run_start_s) state_next_s = ST_FIRST;
                else             state_next_s = ST_IDLE;
            end
`ifdef CAPTURE_TRIGGER_EN
            ST_ARMED: begin
                if (stop)             state_next_s = ST_IDLE;
                else if (trig_rise_s) state_next_s = ST_WAIT_TICK;
                else                  state_next_s = ST_ARMED;
            end
`endif
            ST_WAIT_TICK: begin
                if (stop)        state_next_s = ST_IDLE;
                else if (tick_s) state_next_s = ST_CONVERT;
                else             state_next_s = ST_WAIT_TICK;
            end
            ST_CONVERT: begin
                if (stop) state_next_s = ST_IDLE;
                else      state_next_s = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                if (stop)           state_next_s = ST_IDLE;
                else if (adc_valid) state_next_s = ST_WRITE;
                else if (timeout_s) state_next_s = ST_DONE;
                else                state_next_s = ST_WAIT_DATA;
            end
            ST_WRITE: begin
                if (stop)        state_next_s = ST_IDLE;
                else if (last_s) state_next_s = ST_DONE;
                else             state_next_s = ST_WAIT_TICK;
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // free-running sample divider, parked at reload until the run reaches WAIT_TICK
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r <= DIV_LOAD;
        end else if (hold_div_s || tick_s) begin
            div_r <= DIV_LOAD;
        end else begin
            div_r <= div_r - DIV_W'(1);
        end
    end

    // cycles spent in WAIT_DATA
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= {TMO_W{1'b0}};
        end else if (state_r == ST_WAIT_DATA) begin
            wait_cnt_r <= wait_cnt_r + TMO_W'(1);
        end else begin
            wait_cnt_r <= {TMO_W{1'b0}};
        end
    end

    // sample capture and sticky error flags
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_wdata_r   <= {DATA_W{1'b0}};
            overrun_r     <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            if ((state_r == ST_WAIT_DATA) && adc_valid) begin
                mem_wdata_r <= adc_data;
            end
            if (run_start_s) begin
                overrun_r     <= 1'b0;
                timeout_err_r <= 1'b0;
            end else begin
                if (overrun_set_s) overrun_r     <= 1'b1;
                if (timeout_s)     timeout_err_r <= 1'b1;
            end
        end
    end

    // output decode from registered state
    always_comb begin
        conv_start  = (state_r == ST_CONVERT);
        mem_we      = (state_r == ST_WRITE);
        busy        = (state_r != ST_IDLE);
        done        = (state_r == ST_DONE);
        mem_addr    = addr_s;
        mem_wdata   = mem_wdata_r;
        overrun     = overrun_r;
        timeout_err = timeout_err_r;
    end

endmodule

// File: tb/tb_capture_controller.sv
// Directed bench for capture_controller: two instances (SAMPLE_DIV 4 and 2, ADDR_W 4)
// with a latency-programmable ADC model each; trigger test when CAPTURE_TRIGGER_EN is set.
module tb_capture_controller;

    localparam int AW = 4;
    localparam int DW = 12;
`ifdef CAPTURE_TRIGGER_EN
    localparam int START_LAT = 6;
`else
    localparam int START_LAT = 5;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start_a, start_b, stop;
    logic [AW-1:0] num_samples;
    logic          trig;
    logic          adc_valid_a, adc_valid_b;
    logic [DW-1:0] adc_data_a, adc_data_b;
    logic          conv_start_a, mem_we_a, busy_a, done_a, overrun_a, timeout_err_a;
    logic          conv_start_b, mem_we_b, busy_b, done_b, overrun_b, timeout_err_b;
    logic [AW-1:0] mem_addr_a, mem_addr_b;
    logic [DW-1:0] mem_wdata_a, mem_wdata_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat_a = 2;
    int lat_b = 2;
    int wr_cnt_a = 0, wr_cnt_b = 0, conv_cnt_a = 0, conv_cnt_b = 0;
    int done_cnt_a = 0, done_cnt_b = 0, done_t_a = 0;
    logic [AW-1:0] wr_addr_a [64];
    logic [DW-1:0] wr_data_a [64];
    int            conv_t_a  [64];

    capture_controller #(.ADDR_W(AW), .DATA_W(DW), .SAMPLE_DIV(4), .TIMEOUT(255)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .stop(stop), .num_samples(num_samples),
`ifdef CAPTURE_TRIGGER_EN
        .trig(trig),
`endif
        .adc_valid(adc_valid_a), .adc_data(adc_data_a), .conv_start(conv_start_a),
        .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .busy(busy_a),
        .done(done_a), .overrun(overrun_a), .timeout_err(timeout_err_a)
    );

    capture_controller #(.ADDR_W(AW), .DATA_W(DW), .SAMPLE_DIV(2), .TIMEOUT(255)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .stop(stop), .num_samples(num_samples),
`ifdef CAPTURE_TRIGGER_EN
        .trig(trig),
`endif
        .adc_valid(adc_valid_b), .adc_data(adc_data_b), .conv_start(conv_start_b),
        .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .busy(busy_b),
        .done(done_b), .overrun(overrun_b), .timeout_err(timeout_err_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // event monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (mem_we_a && wr_cnt_a < 64) begin
            wr_addr_a[wr_cnt_a] <= mem_addr_a;
            wr_data_a[wr_cnt_a] <= mem_wdata_a;
        end
        if (mem_we_a) wr_cnt_a <= wr_cnt_a + 1;
        if (conv_start_a && conv_cnt_a < 64) conv_t_a[conv_cnt_a] <= cyc;
        if (conv_start_a) conv_cnt_a <= conv_cnt_a + 1;
        if (done_a) begin
            done_cnt_a <= done_cnt_a + 1;
            done_t_a   <= cyc;
        end
        if (mem_we_b) wr_cnt_b <= wr_cnt_b + 1;
        if (conv_start_b) conv_cnt_b <= conv_cnt_b + 1;
        if (done_b) done_cnt_b <= done_cnt_b + 1;
    end

    // ADC model A: valid is sampled lat_a edges after conv_start is seen (0 = never answers)
    initial begin : adc_a
        int seq;
        seq = 0;
        adc_valid_a = 1'b0;
        adc_data_a  = 12'h000;
        forever begin
            @(posedge clk); #1;
            if (conv_start_a && lat_a > 0) begin
                repeat (lat_a - 1) @(posedge clk);
                #1;
                adc_valid_a = 1'b1;
                adc_data_a  = DW'(12'h100 + seq);
                seq = seq + 1;
                @(posedge clk); #1;
                adc_valid_a = 1'b0;
            end
        end
    end

    // ADC model B
    initial begin : adc_b
        adc_valid_b = 1'b0;
        adc_data_b  = 12'h000;
        forever begin
            @(posedge clk); #1;
            if (conv_start_b && lat_b > 0) begin
                repeat (lat_b - 1) @(posedge clk);
                #1;
                adc_valid_b = 1'b1;
                adc_data_b  = 12'h5A5;
                @(posedge clk); #1;
                adc_valid_b = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input bit sel_b, output int t0);
        @(posedge clk); #1;
        if (sel_b) start_b = 1'b1;
        else       start_a = 1'b1;
        t0 = cyc;
        trig = 1'b0;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
`ifdef CAPTURE_TRIGGER_EN
        trig = 1'b1;
`endif
    endtask

    initial begin
        int t0, w0, c0, d0, n, k;
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; stop = 1'b0;
        num_samples = 4'd0; trig = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_flags_a", {conv_start_a, mem_we_a, busy_a, done_a, overrun_a, timeout_err_a}, 32'h0);
        check("reset_flags_b", {conv_start_b, mem_we_b, busy_b, done_b, overrun_b, timeout_err_b}, 32'h0);
        check("reset_addr", mem_addr_a, 32'h0);
        check("reset_wdata", mem_wdata_a, 32'h0);

        // three samples, with an ignored restart mid-run
        num_samples = 4'd3; lat_a = 2;
        w0 = wr_cnt_a; c0 = conv_cnt_a; d0 = done_cnt_a;
        pulse_start(1'b0, t0);
        check("busy_after_start", busy_a, 32'h1);
        num_samples = 4'd7;
        repeat (4) @(posedge clk);
        #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        num_samples = 4'd3;
        repeat (25) @(posedge clk);
        #1;
        check("run3_writes", wr_cnt_a - w0, 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("run3_addr", wr_addr_a[w0 + i], i);
            check("run3_data", wr_data_a[w0 + i], 32'h100 + i);
        end
        check("run3_first_conv", conv_t_a[c0] - t0, START_LAT);
        check("run3_spacing1", conv_t_a[c0 + 1] - conv_t_a[c0], 32'd4);
        check("run3_spacing2", conv_t_a[c0 + 2] - conv_t_a[c0 + 1], 32'd4);
        check("run3_done_cnt", done_cnt_a - d0, 32'd1);
        check("run3_done_time", done_t_a - t0, START_LAT + 11);
        check("run3_mem_addr", mem_addr_a, 32'd3);
        check("run3_flags", {busy_a, overrun_a, timeout_err_a}, 32'h0);

        // stop together with start in IDLE: start ignored
        @(posedge clk); #1 start_a = 1'b1; stop = 1'b1;
        @(posedge clk); #1 start_a = 1'b0; stop = 1'b0;
        check("stop_start_idle", busy_a, 32'h0);

        // ADC never answers
        lat_a = 0;
        w0 = wr_cnt_a; c0 = conv_cnt_a; d0 = done_cnt_a;
        pulse_start(1'b0, t0);
        repeat (275) @(posedge clk);
        #1;
        check("tmo_flag", timeout_err_a, 32'h1);
        check("tmo_done_cnt", done_cnt_a - d0, 32'd1);
        check("tmo_no_write", wr_cnt_a - w0, 32'd0);
        check("tmo_latency", done_t_a - conv_t_a[c0], 32'd256);
        check("tmo_busy", busy_a, 32'h0);

        // stop while waiting for sample 2
        lat_a = 2;
        w0 = wr_cnt_a; d0 = done_cnt_a;
        pulse_start(1'b0, t0);
        check("start_clears_tmo", timeout_err_a, 32'h0);
        n = 0; k = 0;
        while (n < 2 && k < 100) begin
            @(posedge clk); #1;
            if (conv_start_a) n++;
            k++;
        end
        check("stop_reach_conv2", n, 32'd2);
        @(posedge clk); #1;
        check("stop_in_wait_data", busy_a, 32'h1);
        stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        check("stop_idle", busy_a, 32'h0);
        repeat (20) @(posedge clk);
        #1;
        check("stop_writes", wr_cnt_a - w0, 32'd1);
        check("stop_no_done", done_cnt_a - d0, 32'd0);
        check("stop_mem_addr", mem_addr_a, 32'd1);

        // SAMPLE_DIV=2, ADC three cycles late
        lat_b = 5;
        num_samples = 4'd3;
        w0 = wr_cnt_b; c0 = conv_cnt_b; d0 = done_cnt_b;
        pulse_start(1'b1, t0);
        repeat (40) @(posedge clk);
        #1;
        check("ovr_flag", overrun_b, 32'h1);
        check("ovr_writes", wr_cnt_b - w0, 32'd3);
        check("ovr_convs", conv_cnt_b - c0, 32'd3);
        check("ovr_done", done_cnt_b - d0, 32'd1);
        check("ovr_mem_addr", mem_addr_b, 32'd3);

        // num_samples=0: full 16-entry run with address wrap
        num_samples = 4'd0;
        w0 = wr_cnt_a; d0 = done_cnt_a;
        pulse_start(1'b0, t0);
        repeat (80) @(posedge clk);
        #1;
        check("full_writes", wr_cnt_a - w0, 32'd16);
        for (int i = 0; i < 16; i++) check("full_addr", wr_addr_a[w0 + i], i);
        check("full_done", done_cnt_a - d0, 32'd1);
        check("full_mem_addr", mem_addr_a, 32'd0);
        check("full_overrun", overrun_a, 32'h0);

`ifdef CAPTURE_TRIGGER_EN
        // armed run waits for a trig rising edge
        num_samples = 4'd1;
        c0 = conv_cnt_a;
        trig = 1'b0;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        check("trig_no_conv", conv_cnt_a - c0, 32'd0);
        check("trig_armed_busy", busy_a, 32'h1);
        trig = 1'b1;
        t0 = cyc;
        k = 0;
        while (!conv_start_a && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        check("trig_conv_latency", cyc - t0, 32'd5);
        repeat (10) @(posedge clk);
        #1;
        check("trig_run_done", busy_a, 32'h0);
`endif

        // reset mid-run
        num_samples = 4'd3;
        pulse_start(1'b0, t0);
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check("midrun_reset_flags", {conv_start_a, mem_we_a, busy_a, done_a, overrun_a, timeout_err_a}, 32'h0);
        check("midrun_reset_addr", mem_addr_a, 32'h0);
        check("midrun_reset_wdata", mem_wdata_a, 32'h0);
        c0 = conv_cnt_a;
        repeat (10) @(posedge clk);
        #1;
        check("midrun_reset_stays_idle", conv_cnt_a - c0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
